// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared RV32M funct3 encodings, MDU state encodings and timing.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

   localparam logic [2:0] c_OP_MUL    = 3'b000;
   localparam logic [2:0] c_OP_MULH   = 3'b001;
   localparam logic [2:0] c_OP_MULHSU = 3'b010;
   localparam logic [2:0] c_OP_MULHU  = 3'b011;
   localparam logic [2:0] c_OP_DIV    = 3'b100;
   localparam logic [2:0] c_OP_DIVU   = 3'b101;
   localparam logic [2:0] c_OP_REM    = 3'b110;
   localparam logic [2:0] c_OP_REMU   = 3'b111;

   typedef logic [1:0] state_t;
   localparam state_t c_ST_IDLE = 2'd0;
   localparam state_t c_ST_CALC = 2'd1;
   localparam state_t c_ST_DONE = 2'd2;

   // Start-to-done latency in cycles; one iteration per CALC cycle.
   localparam int unsigned c_LATENCY = 33;
   localparam int unsigned c_ITERS   = c_LATENCY - 1;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_fixup.sv
`default_nettype none
// ============================================================================
// Module      : mdu_fixup
// Description : Sign restoration and special-case result selection at DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_fixup
   import mdu_pkg::*;
(
   input  logic [2:0]  i_op,
   input  logic [63:0] i_acc,
   input  logic        i_s0,
   input  logic        i_s1,
   input  logic        i_dz,
   output logic [31:0] o_res
);

   logic [63:0] w_prod;
   logic [31:0] w_quo;
   logic [31:0] w_rem;

   always_comb begin
      w_prod = (i_s0 ^ i_s1) ? (~i_acc + 64'd1) : i_acc;
      w_quo  = (i_s0 ^ i_s1) ? (~i_acc[31:0] + 32'd1) : i_acc[31:0];
      w_rem  = i_s0 ? (~i_acc[63:32] + 32'd1) : i_acc[63:32];
      o_res  = 32'd0;
      // Signed overflow needs no special case: |MIN|/1 re-signed positive is MIN, remainder 0.
      if (!i_op[2]) begin
         o_res = (i_op == c_OP_MUL) ? w_prod[31:0] : w_prod[63:32];
      end else if (!i_op[1]) begin
         o_res = i_dz ? 32'hFFFF_FFFF : w_quo;
      end else begin
         o_res = w_rem;
      end
   end

endmodule : mdu_fixup
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module      : mdu
// Description : Iterative RV32M multiply/divide unit, fixed 33-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu
   import mdu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        kill_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] in0_i,
   input  logic [31:0] in1_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] out_o
);

   state_t      r_state;
   state_t      w_next;
   logic [4:0]  r_cnt;
   logic [63:0] r_acc;
   logic [31:0] r_opd;
   logic [2:0]  r_op;
   logic        r_s0;
   logic        r_s1;
   logic        r_dz;
   logic [31:0] r_out;

   logic        w_accept;
   logic        w_last;
   logic        w_s0;
   logic        w_s1;
   logic [31:0] w_mag0;
   logic [31:0] w_mag1;
   logic [32:0] w_add;
   logic [32:0] w_sub;
   logic [63:0] w_step;
   logic [31:0] w_fix;

   assign w_accept = start_i & ~kill_i & (r_state != c_ST_CALC);
   assign w_last   = (r_cnt == 5'(c_ITERS - 1));

   // Effective operand signedness; MUL low word is sign-agnostic so it shares MULH's path.
   assign w_s0   = in0_i[31] & (op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11));
   assign w_s1   = in1_i[31] & (op_i[2] ? ~op_i[0] : ~op_i[1]);
   assign w_mag0 = w_s0 ? (~in0_i + 32'd1) : in0_i;
   assign w_mag1 = w_s1 ? (~in1_i + 32'd1) : in1_i;

   assign w_add = {1'b0, r_acc[63:32]} + {1'b0, r_opd};
   assign w_sub = r_acc[63:31] - {1'b0, r_opd};

   // Multiply shifts right adding into the high half; divide shifts left restoring.
   always_comb begin
      w_step = r_acc;
      if (r_op[2]) begin
         w_step = w_sub[32] ? {r_acc[62:0], 1'b0} : {w_sub[31:0], r_acc[30:0], 1'b1};
      end else begin
         w_step = r_acc[0] ? {w_add, r_acc[31:1]} : {1'b0, r_acc[63:1]};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_ST_IDLE: if (w_accept) w_next = c_ST_CALC;
         c_ST_CALC: if (w_last)   w_next = c_ST_DONE;
         c_ST_DONE: w_next = w_accept ? c_ST_CALC : c_ST_IDLE;
         default:   w_next = c_ST_IDLE;
      endcase
      if (kill_i) w_next = c_ST_IDLE;
   end

   always_comb begin
      busy_o = (r_state == c_ST_CALC);
      done_o = (r_state == c_ST_DONE) & ~kill_i;
      out_o  = done_o ? w_fix : r_out;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt <= 5'd0;
         r_acc <= 64'd0;
         r_opd <= 32'd0;
         r_op  <= 3'd0;
         r_s0  <= 1'b0;
         r_s1  <= 1'b0;
         r_dz  <= 1'b0;
         r_out <= 32'd0;
      end else begin
         if (done_o) r_out <= w_fix;
         if (w_accept) begin
            r_op  <= op_i;
            r_s0  <= w_s0;
            r_s1  <= w_s1;
            r_dz  <= (in1_i == 32'd0);
            r_opd <= op_i[2] ? w_mag1 : w_mag0;
            r_acc <= {32'd0, op_i[2] ? w_mag0 : w_mag1};
            r_cnt <= 5'd0;
         end else if ((r_state == c_ST_CALC) && !kill_i) begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 5'd1;
         end
      end
   end

   mdu_fixup u_fixup (
      .i_op  (r_op),
      .i_acc (r_acc),
      .i_s0  (r_s0),
      .i_s1  (r_s1),
      .i_dz  (r_dz),
      .o_res (w_fix)
   );

endmodule : mdu
`default_nettype wire

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL expose `clk_i`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL expose `rst_i`, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL expose `start_i`, input, 1 bit: request a new operation; sampled only when `busy_o`=0.
REQ-004 The block SHALL expose `kill_i`, input, 1 bit: abort the operation in flight (pipeline flush).
REQ-005 The block SHALL expose `op_i`, input, 3 bits: RV32M funct3 -- MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
REQ-006 The block SHALL expose `in0_i`, input, 32 bits: rs1 operand (dividend / multiplicand).
REQ-007 The block SHALL expose `in1_i`, input, 32 bits: rs2 operand (divisor / multiplier).
REQ-008 The block SHALL expose `busy_o`, output, 1 bit: operation in progress.
REQ-009 The block SHALL expose `done_o`, output, 1 bit: one-cycle pulse; `out_o` valid.
REQ-010 The block SHALL expose `out_o`, output, 32 bits: result, held until the next accepted start.

Function
REQ-011 The block SHALL implement states IDLE, CALC and DONE: IDLE->CALC on `start_i`; CALC->DONE after 32 iterations; DONE->IDLE after one cycle (or ->CALC if `start_i`=1 in DONE).
REQ-012 The block SHALL register `op_i`, `in0_i` and `in1_i` at acceptance (start at edge T); input changes afterwards SHALL NOT affect the result.
REQ-013 Timing SHALL be fixed at 33 cycles for every op, including special cases: `busy_o`=1 in cycles T+1..T+32; `done_o`=1 and `out_o` valid in cycle T+33 with `busy_o`=0.
REQ-014 While `busy_o`=1, `start_i` SHALL be ignored and SHALL NOT be queued.
REQ-015 Multiplication SHALL be radix-2 shift-add on operand magnitudes producing a 64-bit product, negated when the effective operand signs differ.
REQ-016 Multiply signedness SHALL be: MULH both operands signed; MULHSU `in0_i` signed and `in1_i` unsigned; MULHU both unsigned.
REQ-017 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32].
REQ-018 Division SHALL be restoring, one quotient bit per cycle, on magnitudes for DIV/REM: quotient sign = sign0 XOR sign1; remainder sign = sign0.
REQ-019 Divide by zero SHALL return quotient 0xFFFFFFFF (DIV and DIVU) and remainder = `in0_i` (REM and REMU).
REQ-020 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL return DIV = 0x80000000 and REM = 0.
REQ-021 `kill_i`=1 in any state SHALL return the block to IDLE at the next edge, suppress `done_o`, and leave `out_o` unchanged; `kill_i` takes priority over `start_i` in the same cycle.
REQ-022 `start_i` together with `kill_i`=0 in DONE SHALL be accepted, with `done_o` still pulsed that cycle.

Reset
REQ-023 Assertion of `rst_i` SHALL immediately force the state to IDLE, `busy_o`=0, `done_o`=0 and `out_o`=0, and clear the iteration counter and internal registers, regardless of the clock.
REQ-024 Reset asserted mid-operation SHALL discard the operation; no `done_o` SHALL follow deassertion.
REQ-025 The first `start_i` SHALL be accepted on the first rising edge after `rst_i` deasserts.

Structure
REQ-026 The funct3 op encodings, the state encodings and the latency constant (33) SHALL live in the shared core package/defines file used by the decoder and the hazard unit.
REQ-027 The block SHALL be a single FSM plus a 5-bit counter and one shared 64-bit accumulator/shift register for both multiply and divide.
REQ-028 The sign-fix and special-case result mux SHALL be a natural sub-module, `mdu_fixup` (combinational), used at DONE.
REQ-029 The block SHALL contain no other sub-modules.

Verification
REQ-030 MUL: start with in0=7, in1=-3 (0xFFFFFFFD) -> `done_o` exactly 33 cycles later, `out_o`=0xFFFFFFEB.
REQ-031 MULH vs MULHU: in0=in1=0xFFFFFFFF -> MULH returns 0x00000000; MULHU returns 0xFFFFFFFE; MULHSU returns 0xFFFFFFFF.
REQ-032 DIV/REM: in0=-20, in1=6 -> DIV 0xFFFFFFFD (-3); REM 0xFFFFFFFE (-2); DIVU 0x2AAAAAA7; REMU 0x00000002.
REQ-033 Special cases: in1=0, in0=0x1234 -> DIVU 0xFFFFFFFF, REM 0x1234; in0=0x80000000, in1=-1 -> DIV 0x80000000, REM 0.
REQ-034 Control: `start_i` at cycle 5 of a busy op -> ignored; `kill_i` at cycle 10 -> no `done_o` and `out_o` unchanged; `rst_i` pulse mid-op -> all outputs 0 asynchronously.
REQ-035 Back-to-back: `start_i` in the DONE cycle -> second `done_o` exactly 33 cycles after the first.
